block_text_emitter: RTL
=======================

Name: block_text_emitter

Overview:
- Token-to-ASCII serializer that generates the space-delimited, case-insensitive "begin"/"end" character stream consumed by BlockChecker; it is the transmit end of that stream.
- Accepts one token per handshake and emits one ASCII character per clock.
- Tracks nesting depth, so it can auto-close open blocks and report whether the emitted stream is balanced.
- Used as a stimulus source and loopback partner for BlockChecker.

Parameters:
- DEPTH_W, 4, width of the nesting-depth counter; maximum depth is 2^DEPTH_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tok_valid  input  1  token offered.
- tok  input  2  token code: 00 SPACE, 01 BEGIN, 10 END, 11 CLOSE_ALL.
- upcase  input  5  per-letter uppercase mask, captured at accept; bit i applies to letter i of the word.
- tok_ready  output  1  emitter can accept a token this cycle.
- out  output  8  ASCII character.
- out_valid  output  1  out carries an emitted character.
- depth  output  DEPTH_W  current nesting depth.
- balanced  output  1  high when depth==0 and err==0.
- err  output  1  sticky error flag: END at depth 0, or BEGIN at max depth.

Behaviour:
- Reset (asynchronous, reset==0):
  - state IDLE, tok_ready=1, out=8'h20, out_valid=0, depth=0, err=0, balanced=1.
  - Reset mid-word aborts the word immediately; no further characters are emitted.
- Accept rule: token accepted on a rising edge where tok_valid && tok_ready. tok and upcase are registered at accept.
- States:
  - IDLE: tok_ready=1, out_valid=0, out=8'h20.
  - EMIT: one character per cycle from the word table; index counter 0..len-1.
  - CLOSE: repeats the "end " word until depth reaches 0.
- Words (a space separator is always appended):
  - SPACE = " " (length 1).
  - BEGIN = "begin " (length 6).
  - END = "end " (length 4).
  - CLOSE_ALL = "end " repeated depth times (length 4*depth).
- Latency: token accepted at edge N gives its first character registered on out from edge N (visible in cycle N+1).
- Back-to-back:
  - tok_ready=1 during the cycle the last character of a word is on out, so the next token's first character follows with no gap.
  - Otherwise tok_ready=0 while emitting.
- Case: letter i emits uppercase (ASCII minus 8'h20) when upcase[i]=1. Spaces are never affected. For CLOSE_ALL the same mask applies to every repetition.
- Depth update:
  - BEGIN: depth+1 at accept.
  - END: depth-1 at accept.
  - CLOSE_ALL: depth-1 at the edge emitting each trailing space; depth reaches 0 with the last space.
- Boundaries:
  - END at depth 0: word still emitted, depth stays 0, err set.
  - BEGIN at depth max: word still emitted, depth saturates, err set.
  - CLOSE_ALL at depth 0: accepted, emits nothing, returns to IDLE next cycle with no out_valid.
  - err clears only on reset.
- Outputs out, out_valid and depth are registered; balanced and tok_ready are combinational from registered state.

Decomposition:
- Package block_text_pkg holds:
  - token codes TOK_SPACE, TOK_BEGIN, TOK_END, TOK_CLOSE_ALL;
  - ASCII constants CH_SPACE, CH_CASE_BIT (8'h20);
  - word lengths LEN_BEGIN=6, LEN_END=4, LEN_SPACE=1;
  - state enum.
- Sub-module block_word_rom: combinational (token, index, upcase) -> ASCII char, with a last-index flag.

Test Plan:
- Reset then idle 5 cycles -> out=8'h20, out_valid=0, depth=0, balanced=1, tok_ready=1.
- BEGIN with upcase=5'b01010, then END with upcase=0, back-to-back -> out stream "bEgIn end " over 10 consecutive cycles, no gap. depth goes 1 then 0; balanced=1 at end.
- Three BEGINs, then CLOSE_ALL -> "begin begin begin end end end ". depth steps 3,2,1,0 on each trailing space. tok_ready=0 throughout CLOSE, then 1.
- END from depth 0 -> "end " emitted, depth=0, err=1, balanced=0. A later BEGIN+END keeps err=1.
- DEPTH_W=2: four BEGINs -> depth saturates at 3 on the 4th, err=1. CLOSE_ALL then emits exactly 3 "end " words.
- Assert reset at the 3rd character of BEGIN -> out_valid=0 and out=8'h20 immediately, depth=0. First token after release starts from its first character.
- Loopback: chain into BlockChecker with random legal token sequences -> checker result equals balanced after each trailing space.

Source files
------------

// File: rtl/block_text_pkg.sv
// block_text_pkg -- token codes, ASCII constants and FSM states for the text emitter.
// Rev 1.0
`default_nettype none

package block_text_pkg;

  localparam logic [1:0] TOK_SPACE     = 2'b00;
  localparam logic [1:0] TOK_BEGIN     = 2'b01;
  localparam logic [1:0] TOK_END       = 2'b10;
  localparam logic [1:0] TOK_CLOSE_ALL = 2'b11;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_CASE_BIT = 8'h20;

  localparam int unsigned LEN_BEGIN = 6;
  localparam int unsigned LEN_END   = 4;
  localparam int unsigned LEN_SPACE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/block_word_rom.sv
// block_word_rom -- maps (token, char index, case mask) to one ASCII character.
// Rev 1.0
`default_nettype none

module block_word_rom
  import block_text_pkg::*;
(
  input  logic [1:0] i_tok,
  input  logic [2:0] i_idx,
  input  logic [4:0] i_upcase,
  output logic [7:0] o_char,
  output logic       o_last
);

  logic [7:0] w_base;
  logic [7:0] w_up_ext;
  logic       w_upper;

  always_comb begin
    w_base = CH_SPACE;
    o_last = 1'b0;
    case (i_tok)
      TOK_SPACE: begin
        o_last = (i_idx == 3'(LEN_SPACE - 1));
      end
      TOK_BEGIN: begin
        case (i_idx)
          3'd0:    w_base = 8'h62; // b
          3'd1:    w_base = 8'h65; // e
          3'd2:    w_base = 8'h67; // g
          3'd3:    w_base = 8'h69; // i
          3'd4:    w_base = 8'h6E; // n
          default: w_base = CH_SPACE;
        endcase
        o_last = (i_idx == 3'(LEN_BEGIN - 1));
      end
      default: begin
        // CLOSE_ALL repeats the END word, so both share this entry.
        case (i_idx)
          3'd0:    w_base = 8'h65; // e
          3'd1:    w_base = 8'h6E; // n
          3'd2:    w_base = 8'h64; // d
          default: w_base = CH_SPACE;
        endcase
        o_last = (i_idx == 3'(LEN_END - 1));
      end
    endcase
  end

  assign w_up_ext = {3'b000, i_upcase};
  assign w_upper  = (w_base != CH_SPACE) && w_up_ext[i_idx];
  assign o_char   = w_upper ? (w_base - CH_CASE_BIT) : w_base;

endmodule

`default_nettype wire

// File: rtl/block_text_emitter.sv
// block_text_emitter -- serializes begin/end/space tokens into a one-char-per-clock
// ASCII stream while tracking nesting depth and balance. Rev 1.0
`default_nettype none

module block_text_emitter
  import block_text_pkg::*;
#(
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tok_valid,
  input  logic [1:0]         tok,
  input  logic [4:0]         upcase,
  output logic               tok_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_t             r_state, w_state;
  logic [1:0]         r_tok, w_tok;
  logic [4:0]         r_upcase, w_upcase;
  logic [2:0]         r_idx, w_idx;
  logic               r_last, w_last;
  logic [7:0]         r_out, w_out;
  logic               r_out_valid, w_out_valid;
  logic [DEPTH_W-1:0] r_depth, w_depth;
  logic               r_err, w_err;

  logic               w_accept;
  logic [1:0]         w_rom_tok;
  logic [2:0]         w_rom_idx;
  logic [4:0]         w_rom_up;
  logic [7:0]         w_rom_char;
  logic               w_rom_last;

  assign tok_ready = (r_state == ST_IDLE) || ((r_state == ST_EMIT) && r_last);
  assign w_accept  = tok_valid && tok_ready;

  // On accept the first character comes straight from the incoming token.
  assign w_rom_tok = w_accept ? tok    : r_tok;
  assign w_rom_idx = w_accept ? 3'd0   : r_idx;
  assign w_rom_up  = w_accept ? upcase : r_upcase;

  block_word_rom u_rom (
    .i_tok    (w_rom_tok),
    .i_idx    (w_rom_idx),
    .i_upcase (w_rom_up),
    .o_char   (w_rom_char),
    .o_last   (w_rom_last)
  );

  always_comb begin
    w_state     = r_state;
    w_tok       = r_tok;
    w_upcase    = r_upcase;
    w_idx       = r_idx;
    w_last      = 1'b0;
    w_out       = CH_SPACE;
    w_out_valid = 1'b0;
    w_depth     = r_depth;
    w_err       = r_err;

    if (w_accept) begin
      w_tok    = tok;
      w_upcase = upcase;
      if (tok == TOK_CLOSE_ALL) begin
        w_state = ST_CLOSE;
        w_idx   = 3'd0;
        if (r_depth != '0) begin
          w_out       = w_rom_char;
          w_out_valid = 1'b1;
          w_idx       = 3'd1;
        end
      end else begin
        w_state     = ST_EMIT;
        w_out       = w_rom_char;
        w_out_valid = 1'b1;
        w_last      = w_rom_last;
        w_idx       = 3'd1;
        if (tok == TOK_BEGIN) begin
          if (r_depth == DEPTH_MAX) w_err = 1'b1;
          else                      w_depth = r_depth + 1'b1;
        end else if (tok == TOK_END) begin
          if (r_depth == '0) w_err = 1'b1;
          else               w_depth = r_depth - 1'b1;
        end
      end
    end else begin
      case (r_state)
        ST_EMIT: begin
          if (r_last) begin
            w_state = ST_IDLE;
          end else begin
            w_out       = w_rom_char;
            w_out_valid = 1'b1;
            w_last      = w_rom_last;
            w_idx       = r_idx + 3'd1;
          end
        end
        ST_CLOSE: begin
          if (r_depth == '0) begin
            w_state = ST_IDLE;
          end else begin
            w_out       = w_rom_char;
            w_out_valid = 1'b1;
            w_idx       = w_rom_last ? 3'd0 : (r_idx + 3'd1);
            if (w_rom_last) begin
              w_depth = r_depth - 1'b1;
              // Final space behaves like the last char of a plain word so the
              // next token can follow without a gap.
              if (r_depth == DEPTH_ONE) begin
                w_state = ST_EMIT;
                w_last  = 1'b1;
              end
            end
          end
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_tok       <= TOK_SPACE;
      r_upcase    <= 5'd0;
      r_idx       <= 3'd0;
      r_last      <= 1'b0;
      r_out       <= CH_SPACE;
      r_out_valid <= 1'b0;
      r_depth     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_tok       <= w_tok;
      r_upcase    <= w_upcase;
      r_idx       <= w_idx;
      r_last      <= w_last;
      r_out       <= w_out;
      r_out_valid <= w_out_valid;
      r_depth     <= w_depth;
      r_err       <= w_err;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign depth     = r_depth;
  assign err       = r_err;
  assign balanced  = (r_depth == '0) && !r_err;

endmodule

`default_nettype wire
